rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one 16-way resource (e.g. the shared bus or register-port path of the 16-bit CPU) among 16 requesters.
- Registers a one-hot grant and its 4-bit encoded index, so downstream datapath selects can use the index directly.
- Grants are held until the owner releases or a hold timeout fires; fairness comes from a rotating priority pointer.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/rr_pick16.sv | 25 ++
 rtl/rr_arbiter16.sv | 108 ++++++++++
 tb/tb_rr_arbiter16.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
package cpu_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Decode a requester index into a one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request bit at or after ptr.
module rr_pick16
    import cpu_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot = N_REQ'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        winner_o = off + ptr_i;
        any_o    = |req_i;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with hold timeout and one-cycle turnaround.
module rr_arbiter16
    import cpu_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid,
    output logic             preempt
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  id_q, id_d;
    logic              vld_q, vld_d;
    logic              pre_q, pre_d;

    logic [IDX_W-1:0]  pick_id;
    logic              pick_any;
    logic              timeout;

    rr_pick16 u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_id),
        .any_o    (pick_any)
    );

    assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Next-state logic: arbitrate in IDLE, hold/release/timeout in GRANT, dead cycle in RELEASE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        id_d    = id_q;
        vld_d   = vld_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (en && pick_any) begin
                    id_d    = pick_id;
                    vld_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release wins over a coincident timeout, so preempt only fires while req is still high.
                if (!req[id_q]) begin
                    id_d    = '0;
                    vld_d   = 1'b0;
                    ptr_d   = id_q + IDX_W'(1);
                    state_d = RELEASE;
                end else if (timeout) begin
                    id_d    = '0;
                    vld_d   = 1'b0;
                    pre_d   = 1'b1;
                    ptr_d   = id_q + IDX_W'(1);
                    state_d = RELEASE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RELEASE: begin
                hold_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                id_d    = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
            pre_q   <= pre_d;
        end
    end

    assign grant       = vld_q ? idx2onehot(id_q) : '0;
    assign grant_id    = id_q;
    assign grant_valid = vld_q;
    assign preempt     = pre_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with an expected-output scoreboard.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        preempt;

    typedef struct {
        logic       vld;
        logic [3:0] id;
        logic       pre;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_arbiter16 #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic v, input logic [3:0] id, input logic p, input string tag);
        exp_t e;
        e.vld = v;
        e.id  = v ? id : 4'd0;
        e.pre = p;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [15:0] eg;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got=%0d want=nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            eg = e.vld ? (16'h0001 << e.id) : 16'h0000;
            checks++;
            assert (grant === eg) else begin
                errors++;
                $error("FAIL %s grant got=%h want=%h", e.tag, grant, eg);
            end
            checks++;
            assert (grant_id === e.id) else begin
                errors++;
                $error("FAIL %s grant_id got=%0d want=%0d", e.tag, grant_id, e.id);
            end
            checks++;
            assert (grant_valid === e.vld) else begin
                errors++;
                $error("FAIL %s grant_valid got=%b want=%b", e.tag, grant_valid, e.vld);
            end
            checks++;
            assert (preempt === e.pre) else begin
                errors++;
                $error("FAIL %s preempt got=%b want=%b", e.tag, preempt, e.pre);
            end
        end
    endtask

    // Drive inputs, record what should appear after the next edge, then compare.
    task automatic step(input logic e_i, input logic [15:0] r_i, input logic v,
                        input logic [3:0] id, input logic p, input string tag);
        en  = e_i;
        req = r_i;
        push_exp(v, id, p, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 4'd0, 1'b0, "reset");
        pop_check();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0000;
        do_reset();

        // single request, release, then pointer check (ptr=3 picks 3 over 2)
        step(1'b1, 16'h0004, 1'b1, 4'd2, 1'b0, "single_grant");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "single_release");
        step(1'b1, 16'h000C, 1'b0, 4'd0, 1'b0, "release_dead");
        step(1'b1, 16'h000C, 1'b1, 4'd3, 1'b0, "ptr_after_release");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "ptr_release");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "ptr_dead");

        // full rotation from ptr=0 with all requesters asking
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [3:0]  own;
            logic [15:0] drop;
            own  = 4'(i);
            drop = 16'hFFFF & ~(16'h0001 << own);
            step(1'b1, 16'hFFFF, 1'b1, own, 1'b0, "rot_grant");
            step(1'b1, 16'hFFFF, 1'b1, own, 1'b0, "rot_hold");
            step(1'b1, drop,     1'b0, 4'd0, 1'b0, "rot_release");
            step(1'b1, 16'hFFFF, 1'b0, 4'd0, 1'b0, "rot_dead");
        end

        // pointer wrap: owner 13 released -> ptr=14, then 15, 0, 2
        step(1'b1, 16'h2000, 1'b1, 4'd13, 1'b0, "wrap_13");
        step(1'b1, 16'h0000, 1'b0, 4'd0,  1'b0, "wrap_13_rel");
        step(1'b1, 16'h8005, 1'b0, 4'd0,  1'b0, "wrap_dead0");
        step(1'b1, 16'h8005, 1'b1, 4'd15, 1'b0, "wrap_15");
        step(1'b1, 16'h0005, 1'b0, 4'd0,  1'b0, "wrap_15_rel");
        step(1'b1, 16'h0005, 1'b0, 4'd0,  1'b0, "wrap_dead1");
        step(1'b1, 16'h0005, 1'b1, 4'd0,  1'b0, "wrap_0");
        step(1'b1, 16'h0004, 1'b0, 4'd0,  1'b0, "wrap_0_rel");
        step(1'b1, 16'h0004, 1'b0, 4'd0,  1'b0, "wrap_dead2");
        step(1'b1, 16'h0004, 1'b1, 4'd2,  1'b0, "wrap_2");
        step(1'b1, 16'h0000, 1'b0, 4'd0,  1'b0, "wrap_2_rel");
        step(1'b1, 16'h0000, 1'b0, 4'd0,  1'b0, "wrap_dead3");

        // timeout: held exactly 15 cycles, preempt pulse, dead cycle, re-grant
        step(1'b1, 16'h0010, 1'b1, 4'd4, 1'b0, "to_grant");
        for (int i = 0; i < 14; i++)
            step(1'b1, 16'h0010, 1'b1, 4'd4, 1'b0, "to_hold");
        step(1'b1, 16'h0010, 1'b0, 4'd0, 1'b1, "to_preempt");
        step(1'b1, 16'h0010, 1'b0, 4'd0, 1'b0, "to_dead");
        step(1'b1, 16'h0010, 1'b1, 4'd4, 1'b0, "to_regrant");

        // release on the timeout cycle counts as a plain release
        for (int i = 0; i < 14; i++)
            step(1'b1, 16'h0010, 1'b1, 4'd4, 1'b0, "rt_hold");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "rt_release");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "rt_dead");

        // enable gating
        step(1'b0, 16'h0100, 1'b0, 4'd0, 1'b0, "en_off0");
        step(1'b0, 16'h0100, 1'b0, 4'd0, 1'b0, "en_off1");
        step(1'b1, 16'h0100, 1'b1, 4'd8, 1'b0, "en_on");
        step(1'b0, 16'h0100, 1'b1, 4'd8, 1'b0, "en_off_hold0");
        step(1'b0, 16'h0300, 1'b1, 4'd8, 1'b0, "en_off_hold1");
        step(1'b0, 16'h0200, 1'b0, 4'd0, 1'b0, "en_off_rel");
        step(1'b1, 16'h0000, 1'b0, 4'd0, 1'b0, "en_dead");

        // async reset in the middle of a grant (ptr=9 here, only 8 asking)
        step(1'b1, 16'h0100, 1'b1, 4'd8, 1'b0, "mid_grant");
        step(1'b1, 16'h0100, 1'b1, 4'd8, 1'b0, "mid_hold");
        #3;
        rst_n = 1'b0;
        #1;
        push_exp(1'b0, 4'd0, 1'b0, "async_reset");
        pop_check();
        #1;
        rst_n = 1'b1;
        step(1'b1, 16'h0300, 1'b1, 4'd8, 1'b0, "post_reset_grant");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
